// File: rtl/ppm_encoder8.sv
// ppm_encoder8 -- eight-channel servo PWM to PPM stream encoder.
//
// Measures the high time of eight asynchronous servo PWM inputs in 1 us
// ticks, clamps each valid measurement to the channel limits, and replays
// the eight widths as a fixed-period active-low PPM frame: nine separator
// pulses whose falling-edge spacing equals each channel width, followed by
// a sync gap that runs until the frame counter wraps.
//
// Ports:
//   wb_clk_i    in   1  system clock
//   wb_rst_i    in   1  asynchronous active-high reset
//   enable      in   1  frame generation enable, sampled at frame boundaries
//   ch_in       in   8  servo PWM inputs, bit 0 = CH1, asynchronous
//   ppm_out_n   out  1  registered PPM output, active-low pulses, idle high
//   frame_start out  1  one-cycle strobe with the first separator of a frame
//   ch_seen     out  8  sticky per-channel "valid pulse measured" flags
module ppm_encoder8 #(
  parameter int TICK_DIV   = 12,
  parameter int SEP_US     = 300,
  parameter int CH_MIN_US  = 900,
  parameter int CH_MAX_US  = 2100,
  parameter int CH_DEF_US  = 1500,
  parameter int FRAME_US   = 22500,
  parameter int TIMEOUT_US = 4095
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       enable,
  input  logic [7:0] ch_in,
  output logic       ppm_out_n,
  output logic       frame_start,
  output logic [7:0] ch_seen
);

  localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [14:0] FRAME_LAST = 15'(FRAME_US - 1);
  localparam logic [11:0] SEP_C      = 12'(SEP_US);
  localparam logic [11:0] SEP_LAST   = 12'(SEP_US - 1);
  localparam logic [11:0] MIN_C      = 12'(CH_MIN_US);
  localparam logic [11:0] MAX_C      = 12'(CH_MAX_US);
  localparam logic [11:0] DEF_C      = 12'(CH_DEF_US);
  localparam logic [11:0] TIMEOUT_C  = 12'(TIMEOUT_US);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEP  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_SYNC = 2'd3;

  // ---------------- 1 us tick and free-running frame counter ----------------
  logic [15:0] tick_cnt_q;
  logic        tick;
  logic [14:0] frame_cnt_q;
  logic        wrap;

  assign tick = (tick_cnt_q == TICK_LAST);
  assign wrap = tick && (frame_cnt_q == FRAME_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tick_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
      if (tick) frame_cnt_q <= wrap ? 15'd0 : frame_cnt_q + 15'd1;
    end
  end

  // ---------------- per-channel pulse measurement ----------------
  logic [7:0][11:0] width_all;

  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    logic        sync1_q, sync2_q, prev_q;
    logic        armed_q, armed_d;
    logic        seen_q, seen_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] width_q, width_d;
    logic        rise, fall;

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    always_comb begin
      cnt_d   = cnt_q;
      width_d = width_q;
      armed_d = armed_q;
      seen_d  = seen_q;
      // The rising-edge cycle is itself a high cycle, so a tick landing on it
      // is counted; this makes an N-tick pulse measure exactly N.
      if (rise) begin
        cnt_d   = tick ? 12'd1 : 12'd0;
        armed_d = 1'b1;
      end else if (sync2_q && tick && (cnt_q < TIMEOUT_C)) begin
        cnt_d = cnt_q + 12'd1;
      end
      // A saturated count means the pulse overran the timeout: drop it.
      if (fall && armed_q && (cnt_q < TIMEOUT_C)) begin
        seen_d = 1'b1;
        if (cnt_q < MIN_C)      width_d = MIN_C;
        else if (cnt_q > MAX_C) width_d = MAX_C;
        else                    width_d = cnt_q;
      end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        prev_q  <= 1'b0;
        armed_q <= 1'b0;
        seen_q  <= 1'b0;
        cnt_q   <= '0;
        width_q <= DEF_C;
      end else begin
        sync1_q <= ch_in[gi];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
        armed_q <= armed_d;
        seen_q  <= seen_d;
        cnt_q   <= cnt_d;
        width_q <= width_d;
      end
    end

    assign width_all[gi] = width_q;
    assign ch_seen[gi]   = seen_q;
  end

  // ---------------- frame generator FSM ----------------
  logic [1:0]       state_q, state_d;
  logic [3:0]       ch_idx_q, ch_idx_d;
  logic [11:0]      seg_cnt_q, seg_cnt_d;
  logic             ppm_q, ppm_d;
  logic             fs_q, fs_d;
  logic [7:0][11:0] shadow_q, shadow_d;
  logic [11:0]      gap_last;
  logic             start_frame;

  // Gap length is width minus separator so separator spacing equals width.
  assign gap_last = shadow_q[ch_idx_q[2:0]] - SEP_C - 12'd1;

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    seg_cnt_d   = seg_cnt_q;
    ppm_d       = ppm_q;
    fs_d        = 1'b0;
    shadow_d    = shadow_q;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ppm_d = 1'b1;
        if (wrap && enable) start_frame = 1'b1;
      end
      ST_SEP: begin
        if (tick) begin
          if (seg_cnt_q == SEP_LAST) begin
            seg_cnt_d = '0;
            ppm_d     = 1'b1;
            state_d   = (ch_idx_q == 4'd8) ? ST_SYNC : ST_GAP;
          end else begin
            seg_cnt_d = seg_cnt_q + 12'd1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (seg_cnt_q == gap_last) begin
            seg_cnt_d = '0;
            ppm_d     = 1'b0;
            ch_idx_d  = ch_idx_q + 4'd1;
            state_d   = ST_SEP;
          end else begin
            seg_cnt_d = seg_cnt_q + 12'd1;
          end
        end
      end
      ST_SYNC: begin
        if (wrap) begin
          if (enable) start_frame = 1'b1;
          else        state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Latch all widths at the frame boundary so mid-frame updates wait a frame.
    if (start_frame) begin
      state_d   = ST_SEP;
      ch_idx_d  = '0;
      seg_cnt_d = '0;
      ppm_d     = 1'b0;
      fs_d      = 1'b1;
      shadow_d  = width_all;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ch_idx_q  <= '0;
      seg_cnt_q <= '0;
      ppm_q     <= 1'b1;
      fs_q      <= 1'b0;
      shadow_q  <= {8{DEF_C}};
    end else begin
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      seg_cnt_q <= seg_cnt_d;
      ppm_q     <= ppm_d;
      fs_q      <= fs_d;
      shadow_q  <= shadow_d;
    end
  end

  assign ppm_out_n   = ppm_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_ppm_encoder8.sv
// Bench for ppm_encoder8, run with timing scaled down (TICK_DIV=2, all
// microsecond parameters divided by 10) so several frames fit in a short run.
module tb_ppm_encoder8;
  localparam int TD        = 2;
  localparam int SEP       = 30;
  localparam int FRAME     = 2250;
  localparam int FRAME_CLK = FRAME * TD;

  typedef logic [7:0][11:0] frame_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] ch_in;
  logic       ppm_out_n;
  logic       frame_start;
  logic [7:0] ch_seen;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t exp_q[$];
  int     plen[8];

  ppm_encoder8 #(
    .TICK_DIV(TD), .SEP_US(SEP), .CH_MIN_US(90), .CH_MAX_US(210),
    .CH_DEF_US(150), .FRAME_US(FRAME), .TIMEOUT_US(409)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .ch_in(ch_in),
    .ppm_out_n(ppm_out_n), .frame_start(frame_start), .ch_seen(ch_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic frame_t mkf(input int a, b, c, d, e, f, g, h);
    frame_t r;
    r[0] = 12'(a); r[1] = 12'(b); r[2] = 12'(c); r[3] = 12'(d);
    r[4] = 12'(e); r[5] = 12'(f); r[6] = 12'(g); r[7] = 12'(h);
    return r;
  endfunction

  // ---------------- output monitor / scoreboard consumer ----------------
  int     cyc;
  int     last_fall;
  int     sep_cnt;
  bit     in_frame;
  logic   prev_ppm;
  frame_t cur;

  initial begin
    cyc = -1; last_fall = 0; sep_cnt = 0; in_frame = 0; prev_ppm = 1'b1; cur = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      cyc      = -1;
      in_frame = 0;
      sep_cnt  = 0;
      prev_ppm = 1'b1;
    end else begin
      cyc++;
      if (frame_start) begin
        $display("frame_start at cycle %0d", cyc);
        chk("frame_phase", 32'(cyc % FRAME_CLK), 0);
        chk("fs_with_sep", ppm_out_n, 0);
        if (in_frame) chk("prev_frame_seps", sep_cnt, 9);
        chk("frame_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        in_frame = 1;
        sep_cnt  = 0;
      end
      if (in_frame) begin
        if (prev_ppm && !ppm_out_n) begin
          if (sep_cnt >= 9) begin
            chk("sep_count", sep_cnt + 1, 9);
          end else if (sep_cnt > 0) begin
            $display("sep %0d spacing %0d clk", sep_cnt, cyc - last_fall);
            chk($sformatf("ch%0d_spacing", sep_cnt), cyc - last_fall,
                32'(cur[sep_cnt-1]) * TD);
          end
          last_fall = cyc;
          sep_cnt++;
        end
        if (!prev_ppm && ppm_out_n) chk("sep_low", cyc - last_fall, SEP * TD);
      end
      prev_ppm = ppm_out_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; each channel is held high for plen[i] ticks exactly.
  task automatic drive_pulses();
    int mx = 0;
    for (int i = 0; i < 8; i++) if (plen[i] > mx) mx = plen[i];
    for (int t = 0; t <= mx * TD; t++) begin
      for (int i = 0; i < 8; i++) ch_in[i] = (t < plen[i] * TD);
      @(posedge clk); #1;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic set_plen(input int a, b, c, d, e, f, g, h);
    plen[0] = a; plen[1] = b; plen[2] = c; plen[3] = d;
    plen[4] = e; plen[5] = f; plen[6] = g; plen[7] = h;
  endtask

  // Bounded wait for frame_start; returns at a negedge with clocks waited.
  task automatic wait_fs(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!frame_start && n < 2 * FRAME_CLK);
    chk(tag, frame_start, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, nfs, nlow;
    rst = 1'b1; enable = 1'b0; ch_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ppm", ppm_out_n, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_seen", ch_seen, 0);

    // Frame 1: defaults, first frame_start one full frame after release.
    enable = 1'b1;
    exp_q.push_back(mkf(150, 150, 150, 150, 150, 150, 150, 150));
    @(posedge clk); #1;
    rst = 1'b0;
    wait_fs("fs1", n);
    chk("fs1_latency", n, FRAME_CLK);

    // CH3 1200 us pulse during frame 1 shows up in frame 2 only.
    @(posedge clk); #1;
    set_plen(0, 0, 120, 0, 0, 0, 0, 0);
    drive_pulses();
    chk("seen_ch3", ch_seen, 8'h04);
    exp_q.push_back(mkf(150, 150, 120, 150, 150, 150, 150, 150));
    wait_fs("fs2", n);

    // Clamp low, clamp high, timeout discard, and CH5 = 1000 us.
    @(posedge clk); #1;
    set_plen(50, 260, 0, 500, 100, 0, 0, 0);
    drive_pulses();
    chk("seen_clamp", ch_seen, 8'h17);
    exp_q.push_back(mkf(90, 210, 120, 150, 100, 150, 150, 150));
    wait_fs("fs3", n);

    // CH5 changes to 2000 us mid-frame: frame 3 keeps 1000, frame 4 gets 2000.
    repeat (400) @(posedge clk);
    #1;
    set_plen(0, 0, 0, 0, 200, 0, 0, 0);
    drive_pulses();
    chk("seen_ch5", ch_seen, 8'h17);
    exp_q.push_back(mkf(90, 210, 120, 150, 200, 150, 150, 150));
    wait_fs("fs4", n);

    // Drop enable 5000 us into frame 4: frame completes, then silence.
    repeat (1000) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3000) @(posedge clk);
    #1;
    chk("f4_seps", sep_cnt, 9);
    nfs = 0; nlow = 0;
    repeat (2 * FRAME_CLK) begin
      @(negedge clk);
      if (frame_start) nfs++;
      if (!ppm_out_n) nlow++;
    end
    chk("disabled_fs", nfs, 0);
    chk("disabled_low", nlow, 0);

    // Re-enable between wraps: next frame starts on a wrap (phase checked).
    @(posedge clk); #1;
    exp_q.push_back(mkf(90, 210, 120, 150, 200, 150, 150, 150));
    enable = 1'b1;
    wait_fs("fs5", n);

    // Reset during the first separator of frame 5.
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_sep", ppm_out_n, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ppm", ppm_out_n, 1);
    chk("rst_mid_fs", frame_start, 0);
    chk("rst_mid_seen", ch_seen, 0);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mkf(150, 150, 150, 150, 150, 150, 150, 150));
    rst = 1'b0;
    wait_fs("fs6", n);
    chk("fs6_latency", n, FRAME_CLK);
    repeat (3700) @(posedge clk);
    #1;
    chk("f6_seps", sep_cnt, 9);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
